multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/clk_div_pkg.sv | 52 +++++
 rtl/clk_div_chan.sv | 103 ++++++++++
 rtl/multi_clk_div.sv | 74 +++++++
 tb/tb_multi_clk_div.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: default widths,
// reset divisor, and a lookup of divisors for common output frequencies
// assuming a 100 MHz reference clock.
package clk_div_pkg;

  // Default divisor/counter width; 29 bits covers the reset divisor below.
  localparam int CNT_W_DEFAULT = 29;

  // Divisor loaded at reset: roughly 0.5 Hz square output at 100 MHz.
  localparam int unsigned DIV_RESET_DEFAULT = 32'd100_000_000;

  // Reference clock the frequency table is computed for.
  localparam int unsigned CLK_HZ = 32'd100_000_000;

  // Selectable standard output frequencies.
  typedef enum logic [2:0] {
    FREQ_0HZ5  = 3'd0,
    FREQ_1HZ   = 3'd1,
    FREQ_1KHZ  = 3'd2,
    FREQ_1MHZ  = 3'd3,
    FREQ_10MHZ = 3'd4,
    FREQ_25MHZ = 3'd5,
    FREQ_50MHZ = 3'd6
  } freq_e;

  // Divisor d gives a square wave of CLK_HZ / (2 * (d + 1)), so each entry
  // is CLK_HZ / (2 * f) - 1. The 50 MHz entry is the fastest possible
  // output (toggle every reference cycle).
  localparam int unsigned DIV_0HZ5  = 32'd99_999_999;
  localparam int unsigned DIV_1HZ   = 32'd49_999_999;
  localparam int unsigned DIV_1KHZ  = 32'd49_999;
  localparam int unsigned DIV_1MHZ  = 32'd49;
  localparam int unsigned DIV_10MHZ = 32'd4;
  localparam int unsigned DIV_25MHZ = 32'd1;
  localparam int unsigned DIV_50MHZ = 32'd0;

  // Map a frequency selector onto its divisor; unknown codes fall back to
  // the reset divisor so a bad selector never produces a runaway clock.
  function automatic int unsigned freq_div(input freq_e f);
    case (f)
      FREQ_0HZ5:  return DIV_0HZ5;
      FREQ_1HZ:   return DIV_1HZ;
      FREQ_1KHZ:  return DIV_1KHZ;
      FREQ_1MHZ:  return DIV_1MHZ;
      FREQ_10MHZ: return DIV_10MHZ;
      FREQ_25MHZ: return DIV_25MHZ;
      FREQ_50MHZ: return DIV_50MHZ;
      default:    return DIV_RESET_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, output toggle and a one-deep
// pending-divisor register that is applied only at a period boundary so
// the output never shows a truncated or stretched half-period.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,      // accepted load addressed to this channel
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] div_sel_q, div_sel_d;
  logic [CNT_W-1:0] div_next_q, div_next_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;

  logic             at_boundary;
  logic             restart;

  // Next-state: count, toggle at the boundary, swap divisors when a new
  // period starts (boundary, disable or sync).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    div_sel_d  = div_sel_q;
    div_next_d = div_next_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;

    at_boundary = (cnt_q == div_sel_q);
    // Any event that begins a fresh period is a safe point to switch.
    restart     = sync || !en || at_boundary;

    if (restart) begin
      cnt_d = '0;
      if (sync || !en) begin
        // Sync and disable park the output low, overriding a boundary.
        clk_out_d = 1'b0;
      end else begin
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
      end
      if (pend_q) begin
        div_sel_d = div_next_q;
        pend_d    = 1'b0;
      end
      // A load that lands on a period start goes live immediately.
      if (load) begin
        div_sel_d  = load_div;
        div_next_d = load_div;
        pend_d     = 1'b0;
      end
    end else begin
      // cnt_q < div_sel_q here, so the increment can never wrap.
      cnt_d = cnt_q + 1'b1;
      if (load) begin
        div_next_d = load_div;
        pend_d     = 1'b1;
      end
    end
  end

  // State register; reset discards any pending divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (!rst_n) begin
      div_sel_q  <= DIV_INIT;
      div_next_q <= DIV_INIT;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      div_sel_q  <= div_sel_d;
      div_next_q <= div_next_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign pend    = pend_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider. Holds the shared load port
// decode and handshake; each channel is an independent clk_div_chan.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DIV_RESET = DIV_RESET_DEFAULT,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,         // active-low, asynchronous assert
  input  logic [NUM_CH-1:0] En,
  input  logic              Sync,
  input  logic              Load_Valid,
  input  logic [CH_W-1:0]   Load_Ch,
  input  logic [CNT_W-1:0]  Load_Div,
  output logic              Load_Ready,
  output logic              Load_Err,
  output logic [NUM_CH-1:0] Pend,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] ClkOut
);

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] chan_load;
  logic              in_range;
  logic              load_fire;
  logic              load_err_q, load_err_d;

  // Load decode: one-hot channel select, back-pressure only while the
  // addressed channel already holds a pending divisor.
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (Load_Ch == CH_W'(i));
    end
    in_range   = |ch_hit;
    Load_Ready = ~|(ch_hit & Pend);
    load_fire  = Load_Valid & Load_Ready;
    chan_load  = ch_hit & {NUM_CH{load_fire}};
    // Out-of-range loads are accepted but only flag an error.
    load_err_d = load_fire & ~in_range;
  end

  // Registered error pulse for out-of-range loads.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign Load_Err = load_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_chan (
      .clk      (Clk),
      .rst_n    (Rst),
      .en       (En[g]),
      .sync     (Sync),
      .load     (chan_load[g]),
      .load_div (Load_Div),
      .tick     (Tick[g]),
      .clk_out  (ClkOut[g]),
      .pend     (Pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: directed scenarios plus a random
// run, all compared cycle by cycle against a period-level reference model.
module tb_multi_clk_div;

  localparam int NUM_CH    = 5;
  localparam int CNT_W     = 8;
  localparam int DIV_RESET = 6;
  localparam int CH_W      = 3;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NUM_CH-1:0] En;
  logic              Sync;
  logic              Load_Valid;
  logic [CH_W-1:0]   Load_Ch;
  logic [CNT_W-1:0]  Load_Div;
  logic              Load_Ready;
  logic              Load_Err;
  logic [NUM_CH-1:0] Pend;
  logic [NUM_CH-1:0] Tick;
  logic [NUM_CH-1:0] ClkOut;

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel, the period length in use, how many cycles
  // of the current period have elapsed, and a queued divisor.
  int m_div  [NUM_CH];
  int m_nxt  [NUM_CH];
  int m_age  [NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_err;

  multi_clk_div #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .Sync       (Sync),
    .Load_Valid (Load_Valid),
    .Load_Ch    (Load_Ch),
    .Load_Div   (Load_Div),
    .Load_Ready (Load_Ready),
    .Load_Err   (Load_Err),
    .Pend       (Pend),
    .Tick       (Tick),
    .ClkOut     (ClkOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = DIV_RESET; m_nxt[c] = DIV_RESET; m_age[c] = 0;
      m_lvl[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
    end
    m_err = 0;
  endfunction

  function automatic bit exp_ready();
    int ch = int'(Load_Ch);
    if (ch < NUM_CH) return !m_pend[ch];
    return 1'b1;
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  function automatic void model_step();
    int ch = int'(Load_Ch);
    bit acc = Load_Valid && exp_ready();
    m_err = acc && (ch >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      bit ld = acc && (ch == c);
      if (Sync || !En[c]) begin
        m_age[c] = 0; m_lvl[c] = 0; m_tick[c] = 0;
        if (m_pend[c]) begin m_div[c] = m_nxt[c]; m_pend[c] = 0; end
        if (ld) m_div[c] = int'(Load_Div);
      end else begin
        m_age[c]++;
        if (m_age[c] == m_div[c] + 1) begin
          m_age[c] = 0; m_lvl[c] = !m_lvl[c]; m_tick[c] = 1;
          if (m_pend[c]) begin m_div[c] = m_nxt[c]; m_pend[c] = 0; end
          if (ld) m_div[c] = int'(Load_Div);
        end else begin
          m_tick[c] = 0;
          if (ld) begin m_nxt[c] = int'(Load_Div); m_pend[c] = 1; end
        end
      end
    end
  endfunction

  // Expected {Tick, ClkOut, Pend, Load_Err} from the model.
  function automatic logic [3*NUM_CH:0] exp_all();
    logic [NUM_CH-1:0] t, k, p;
    for (int c = 0; c < NUM_CH; c++) begin
      t[c] = m_tick[c]; k[c] = m_lvl[c]; p[c] = m_pend[c];
    end
    return {t, k, p, m_err};
  endfunction

  // One rising edge; outputs are settled when this returns.
  task automatic clk_cycle();
    @(posedge Clk);
    if (!Rst) model_reset();
    else      model_step();
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; En = '0; Sync = 1'b0;
    Load_Valid = 1'b0; Load_Ch = '0; Load_Div = '0;
    model_reset();
    clk_cycle();
    Rst = 1'b1;
  endtask

  task automatic load_now(input int ch, input int div);
    Load_Valid = 1'b1; Load_Ch = CH_W'(ch); Load_Div = CNT_W'(div);
    clk_cycle();
    Load_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; En = '1; Sync = 1'b0;
    Load_Valid = 1'b0; Load_Ch = '0; Load_Div = '0;
    model_reset();
    #2;
    checks++;
    if ({Tick, ClkOut, Pend, Load_Err, Load_Ready} !== {{3*NUM_CH{1'b0}}, 2'b01}) begin
      failures++;
      $display("FAIL reset_state got %b want %b",
               {Tick, ClkOut, Pend, Load_Err, Load_Ready}, {{3*NUM_CH{1'b0}}, 2'b01});
    end
    clk_cycle();
    clk_cycle();
    Rst = 1'b1; En = '0;
    for (int k = 0; k < 3; k++) begin
      clk_cycle();
      checks++;
      if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
        failures++;
        $display("FAIL reset_idle k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
      end
    end
  endtask

  task automatic test_basic();
    int high_cnt = 0;
    do_reset();
    load_now(0, 3);
    checks++;
    if (Pend[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_direct_load pend0 got %b want 0", Pend[0]);
    end
    En = 5'b00001;
    for (int k = 1; k <= 24; k++) begin
      clk_cycle();
      if (ClkOut[0]) high_cnt++;
      checks++;
      if (Tick[0] !== ((k % 4) == 0)) begin
        failures++;
        $display("FAIL basic_tick k=%0d got %b want %b", k, Tick[0], (k % 4) == 0);
      end
      checks++;
      if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
        failures++;
        $display("FAIL basic_model k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
      end
    end
    checks++;
    if (high_cnt != 12) begin
      failures++;
      $display("FAIL basic_duty high cycles got %0d want 12", high_cnt);
    end
  endtask

  task automatic test_pending();
    do_reset();
    load_now(1, 9);
    En = 5'b00010;
    for (int k = 0; k < 4; k++) clk_cycle();
    load_now(1, 1);
    checks++;
    if (Pend[1] !== 1'b1) begin
      failures++;
      $display("FAIL pend_set pend1 got %b want 1", Pend[1]);
    end
    Load_Valid = 1'b1; Load_Ch = 3'd1; Load_Div = 8'd7;
    #1;
    checks++;
    if (Load_Ready !== 1'b0) begin
      failures++;
      $display("FAIL pend_ready got %b want 0", Load_Ready);
    end
    for (int k = 1; k <= 12; k++) begin
      clk_cycle();
      Load_Valid = 1'b0;
      checks++;
      if ({Tick[1], Pend[1]} !== {(k >= 5) && (k % 2 == 1), k < 5}) begin
        failures++;
        $display("FAIL pend_switch k=%0d tick/pend got %b want %b", k, {Tick[1], Pend[1]},
                 {(k >= 5) && (k % 2 == 1), k < 5});
      end
      checks++;
      if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
        failures++;
        $display("FAIL pend_model k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
      end
    end
  endtask

  task automatic test_bad_load();
    for (int n = 0; n < 2; n++) begin
      Load_Valid = 1'b1; Load_Ch = (n == 0) ? 3'd5 : 3'd7; Load_Div = 8'd3;
      #1;
      checks++;
      if (Load_Ready !== 1'b1) begin
        failures++;
        $display("FAIL bad_ready ch=%0d got %b want 1", Load_Ch, Load_Ready);
      end
      clk_cycle();
      Load_Valid = 1'b0;
      checks++;
      if ({Load_Err, Pend} !== {1'b1, 5'b00000}) begin
        failures++;
        $display("FAIL bad_err_pulse got %b want %b", {Load_Err, Pend}, {1'b1, 5'b00000});
      end
      for (int k = 0; k < 4; k++) begin
        clk_cycle();
        checks++;
        if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
          failures++;
          $display("FAIL bad_model k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
        end
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    load_now(0, 2);
    load_now(2, 4);
    En = 5'b00101;
    repeat ($urandom_range(3, 9)) clk_cycle();
    Sync = 1'b1;
    clk_cycle();
    Sync = 1'b0;
    checks++;
    if ({ClkOut[2], ClkOut[0], Tick} !== 7'b0) begin
      failures++;
      $display("FAIL sync_clear got %b want 0", {ClkOut[2], ClkOut[0], Tick});
    end
    for (int k = 1; k <= 15; k++) begin
      clk_cycle();
      checks++;
      if ({Tick[2], Tick[0]} !== {(k % 5) == 0, (k % 3) == 0}) begin
        failures++;
        $display("FAIL sync_align k=%0d got %b want %b", k, {Tick[2], Tick[0]},
                 {(k % 5) == 0, (k % 3) == 0});
      end
      checks++;
      if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
        failures++;
        $display("FAIL sync_model k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    En = 5'b01001;
    for (int k = 0; k < 8; k++) clk_cycle();
    load_now(0, 2);
    checks++;
    if ({Pend[0], ClkOut[3], ClkOut[0]} !== 3'b111) begin
      failures++;
      $display("FAIL rstmid_pre got %b want 111", {Pend[0], ClkOut[3], ClkOut[0]});
    end
    #3;
    Rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({Tick, ClkOut, Pend, Load_Err} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got %b want 0", {Tick, ClkOut, Pend, Load_Err});
    end
    clk_cycle();
    Rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      clk_cycle();
      checks++;
      if ({Tick[0], Pend[0]} !== {k == DIV_RESET + 1, 1'b0}) begin
        failures++;
        $display("FAIL rstmid_divreset k=%0d got %b want %b", k, {Tick[0], Pend[0]},
                 {k == DIV_RESET + 1, 1'b0});
      end
    end
  endtask

  task automatic test_div0();
    do_reset();
    load_now(3, 0);
    En = 5'b01000;
    for (int k = 1; k <= 8; k++) begin
      clk_cycle();
      checks++;
      if ({Tick[3], ClkOut[3]} !== {1'b1, (k % 2) == 1}) begin
        failures++;
        $display("FAIL div0 k=%0d got %b want %b", k, {Tick[3], ClkOut[3]}, {1'b1, (k % 2) == 1});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) En = NUM_CH'($urandom_range(0, 31));
      Sync       = ($urandom_range(0, 40) == 0);
      Load_Valid = ($urandom_range(0, 3) == 0);
      Load_Ch    = CH_W'($urandom_range(0, 7));
      Load_Div   = CNT_W'($urandom_range(0, 12));
      #1;
      checks++;
      if (Load_Ready !== exp_ready()) begin
        failures++;
        $display("FAIL rand_ready k=%0d got %b want %b", k, Load_Ready, exp_ready());
      end
      clk_cycle();
      checks++;
      if ({Tick, ClkOut, Pend, Load_Err} !== exp_all()) begin
        failures++;
        $display("FAIL rand_model k=%0d got %b want %b", k, {Tick, ClkOut, Pend, Load_Err}, exp_all());
      end
    end
    Sync = 1'b0; Load_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_bad_load();
    test_sync();
    test_reset_mid();
    test_div0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
